// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch-stage branch predictor.
package cpu_pkg;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam int          INST_ALIGN_W = 2;

  // Entry view sized for the widest supported build; narrower builds zero-extend.
  localparam int TAG_MAX_W = 32;
  localparam int CNT_MAX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [CNT_MAX_W-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for an up/down saturating counter with a force-to-max override.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] value,
  input  logic             inc,
  input  logic             dec,
  input  logic             set_max,
  output logic [CNT_W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (set_max) begin
      next_value = '1;
    end else if (inc && (value != '1)) begin
      next_value = value + CNT_W'(1);
    end else if (dec && (value != '0)) begin
      next_value = value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency lookup for IF,
// update and misprediction flag for resolved branches, wrap-around perf counters.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [31:0]       pred_target_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [31:0]       upd_pred_target_i,
  output logic              mispredict_o,
  output logic [PERF_W-1:0] perf_branches_o,
  output logic [PERF_W-1:0] perf_mispred_o
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int IDX_HI = IDX_W + INST_ALIGN_W - 1;
  localparam int TAG_LO = IDX_W + INST_ALIGN_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry;
  logic             up_hit, up_t;
  logic [CNT_W-1:0] cnt_next, alloc_cnt;
  logic             unused_bits;

  assign lk_idx = lookup_pc_i[IDX_HI:INST_ALIGN_W];
  assign lk_tag = lookup_pc_i[TAG_LO +: TAG_W];
  assign up_idx = upd_pc_i[IDX_HI:INST_ALIGN_W];
  assign up_tag = upd_pc_i[TAG_LO +: TAG_W];

  always_comb begin
    lk_entry = '{valid:  valid_q[lk_idx],
                 tag:    TAG_MAX_W'(tag_q[lk_idx]),
                 target: target_q[lk_idx],
                 cnt:    CNT_MAX_W'(cnt_q[lk_idx])};
    up_entry = '{valid:  valid_q[up_idx],
                 tag:    TAG_MAX_W'(tag_q[up_idx]),
                 target: target_q[up_idx],
                 cnt:    CNT_MAX_W'(cnt_q[up_idx])};
  end

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign hit_o         = lk_entry.valid && (lk_entry.tag[TAG_W-1:0] == lk_tag);
  assign pred_taken_o  = hit_o && lk_entry.cnt[CNT_W-1];
  assign pred_target_o = pred_taken_o ? lk_entry.target : (lookup_pc_i + PC_STEP);

  assign up_t   = upd_is_jump_i | upd_taken_i;
  assign up_hit = up_entry.valid && (up_entry.tag[TAG_W-1:0] == up_tag);

  assign mispredict_o = upd_valid_i &
                        ((up_t != upd_pred_taken_i) |
                         (up_t & (upd_pred_target_i != upd_target_i)));

  sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .value      (up_entry.cnt[CNT_W-1:0]),
    .inc        (up_t),
    .dec        (!up_t),
    .set_max    (upd_is_jump_i),
    .next_value (cnt_next)
  );

  assign alloc_cnt = upd_is_jump_i ? '1 : CNT_WEAK;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q         <= '0;
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else if (upd_valid_i) begin
      perf_branches_o <= perf_branches_o + PERF_W'(1);
      if (mispredict_o) perf_mispred_o <= perf_mispred_o + PERF_W'(1);
      if (!up_hit && up_t) valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload fields are unreset; a write landing during reset stays hidden behind a cleared valid bit.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_next;
        if (up_t) target_q[up_idx] <= upd_target_i;
      end else if (up_t) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target_i;
        cnt_q[up_idx]    <= alloc_cnt;
      end
    end
  end

  assign unused_bits = ^{upd_pc_i, lk_entry, up_entry};

endmodule
